// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO PHY-side responder, oversampling MDC/MDIO on CLK
// and bridging read/write frames to an external 32x16 register bank via one-CLK strobes.
module mdio_phy_responder #(
   parameter logic [4:0] P_PHYADR   = 5'h1,
   parameter bit         P_BCAST_EN = 1'b0,
   parameter int         P_PREAMBLE = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MDC,
   input  logic        MDIO_I,
   output logic        MDIO_O,
   output logic        MDIO_T,
   output logic [4:0]  REG_ADDR,
   output logic        REG_WR,
   output logic [15:0] REG_WDATA,
   output logic        REG_RD,
   input  logic [15:0] REG_RDATA,
   output logic        BUSY
);
   localparam int PW = $clog2(P_PREAMBLE + 2);
   localparam logic [PW-1:0] PRE = PW'(P_PREAMBLE);

   typedef enum logic [2:0] {IDLE, ST1, OP, ADDR, SKIP, TA, DATA} state_t;

   state_t        state, state_n;
   logic [1:0]    mdc_s, mdio_s;
   logic          mdc_q;
   logic [4:0]    cnt, cnt_n;
   logic [15:0]   sreg, sreg_n;
   logic          rd, rd_n;
   logic [4:0]    rad, rad_n;
   logic [PW-1:0] pre_cnt, pre_n;
   logic          o_n, t_n, wr_n, rds_n, busy_n;
   logic [4:0]    addr_n;
   logic [15:0]   wdata_n;
   logic          rise, fall, din, match;
   logic [9:0]    a;

   assign rise  = mdc_s[1] & ~mdc_q;
   assign fall  = ~mdc_s[1] & mdc_q;
   assign din   = mdio_s[1];
   assign a     = {sreg[8:0], din};
   // broadcast address only ever accepts writes; a broadcast read would collide on the line
   assign match = (a[9:5] == P_PHYADR) || (P_BCAST_EN && a[9:5] == 5'd0 && !rd);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sreg_n  = REG_RD ? REG_RDATA : sreg;
      rd_n    = rd;
      rad_n   = rad;
      pre_n   = pre_cnt;
      o_n     = MDIO_O;
      t_n     = MDIO_T;
      wr_n    = 1'b0;
      rds_n   = 1'b0;
      addr_n  = REG_ADDR;
      wdata_n = REG_WDATA;
      case (state)
         IDLE: if (rise) begin
            if (din) pre_n = (pre_cnt >= PRE) ? pre_cnt : pre_cnt + 1'b1;
            else begin
               pre_n = '0;
               if (pre_cnt >= PRE) state_n = ST1;
            end
         end
         ST1: if (rise) begin
            state_n = din ? OP : IDLE;
            cnt_n   = '0;
         end
         OP: if (rise) begin
            sreg_n = {sreg[14:0], din};
            cnt_n  = cnt + 5'd1;
            if (cnt[0]) begin
               cnt_n   = '0;
               rd_n    = sreg[0];
               state_n = (sreg[0] ^ din) ? ADDR : IDLE;
            end
         end
         ADDR: if (rise) begin
            sreg_n = {sreg[14:0], din};
            cnt_n  = cnt + 5'd1;
            if (cnt == 5'd9) begin
               cnt_n   = '0;
               rad_n   = a[4:0];
               state_n = match ? TA : SKIP;
               if (match && rd) begin
                  rds_n  = 1'b1;
                  addr_n = a[4:0];
               end
            end
         end
         SKIP: if (rise) begin
            cnt_n = cnt + 5'd1;
            if (cnt == 5'd17) state_n = IDLE;
         end
         TA: if (rise) begin
            cnt_n = cnt + 5'd1;
            if (cnt[0]) begin
               cnt_n   = '0;
               state_n = DATA;
            end
         end else if (fall && rd && cnt[0]) begin
            t_n = 1'b0;
            o_n = 1'b0;
         end
         DATA: if (rd) begin
            if (fall) begin
               if (cnt == 5'd16) begin
                  t_n     = 1'b1;
                  o_n     = 1'b1;
                  state_n = IDLE;
               end else begin
                  o_n    = sreg[15];
                  sreg_n = {sreg[14:0], 1'b0};
               end
            end else if (rise) cnt_n = cnt + 5'd1;
         end else if (rise) begin
            sreg_n = {sreg[14:0], din};
            cnt_n  = cnt + 5'd1;
            if (cnt == 5'd15) begin
               wr_n    = 1'b1;
               addr_n  = rad;
               wdata_n = {sreg[14:0], din};
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = state_n != IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         mdc_s     <= '0;
         mdio_s    <= '0;
         mdc_q     <= 1'b0;
         cnt       <= '0;
         sreg      <= '0;
         rd        <= 1'b0;
         rad       <= '0;
         pre_cnt   <= '0;
         MDIO_O    <= 1'b1;
         MDIO_T    <= 1'b1;
         REG_WR    <= 1'b0;
         REG_RD    <= 1'b0;
         REG_ADDR  <= '0;
         REG_WDATA <= '0;
         BUSY      <= 1'b0;
      end else begin
         state     <= state_n;
         mdc_s     <= {mdc_s[0], MDC};
         mdio_s    <= {mdio_s[0], MDIO_I};
         mdc_q     <= mdc_s[1];
         cnt       <= cnt_n;
         sreg      <= sreg_n;
         rd        <= rd_n;
         rad       <= rad_n;
         pre_cnt   <= pre_n;
         MDIO_O    <= o_n;
         MDIO_T    <= t_n;
         REG_WR    <= wr_n;
         REG_RD    <= rds_n;
         REG_ADDR  <= addr_n;
         REG_WDATA <= wdata_n;
         BUSY      <= busy_n;
      end
   end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: bit-banged MDIO station driving the responder, with a register
// bank on the strobe side and a scoreboard of expected strobes.
module tb_mdio_phy_responder;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        MDC = 1'b0;
   logic        MDIO_O, MDIO_T, REG_WR, REG_RD, BUSY;
   logic [4:0]  REG_ADDR;
   logic [15:0] REG_WDATA, REG_RDATA;
   logic        st_oe = 1'b0, st_d = 1'b1;
   logic        mdio_line;
   logic [15:0] bank [32];
   int          compared = 0, mismatched = 0;
   int          h = 5;
   bit          t_low_seen = 1'b0;

   typedef struct packed {logic wr; logic [4:0] a; logic [15:0] d;} exp_t;
   exp_t sb[$];

   assign mdio_line = !MDIO_T ? MDIO_O : (st_oe ? st_d : 1'b1);
   assign REG_RDATA = bank[REG_ADDR];

   mdio_phy_responder dut (
      .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_I(mdio_line),
      .MDIO_O(MDIO_O), .MDIO_T(MDIO_T), .REG_ADDR(REG_ADDR), .REG_WR(REG_WR),
      .REG_WDATA(REG_WDATA), .REG_RD(REG_RD), .REG_RDATA(REG_RDATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (REG_WR) bank[REG_ADDR] <= REG_WDATA;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      compared++;
      assert (o === e) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   always @(negedge CLK) begin
      if (!MDIO_T) t_low_seen = 1'b1;
      if (REG_WR || REG_RD) begin
         exp_t e;
         chk("strobe_exclusive", {31'd0, REG_WR & REG_RD}, 32'd0);
         if (sb.size() == 0) chk("strobe_unexpected", {31'd0, REG_WR}, {31'd0, ~REG_WR});
         else begin
            e = sb.pop_front();
            chk("strobe_kind", {31'd0, REG_WR}, {31'd0, e.wr});
            chk("strobe_addr", {27'd0, REG_ADDR}, {27'd0, e.a});
            if (e.wr) chk("strobe_wdata", {16'd0, REG_WDATA}, {16'd0, e.d});
         end
      end
   end

   task automatic cyc(input bit drv, input bit b, output bit s);
      @(negedge CLK);
      MDC = 1'b0;
      st_oe = drv;
      st_d = b;
      repeat (h) @(negedge CLK);
      MDC = 1'b1;
      s = mdio_line;
      repeat (h) @(negedge CLK);
   endtask

   task automatic send(input logic [63:0] v, input int n);
      bit s;
      for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i], s);
   endtask

   task automatic idle_low();
      @(negedge CLK);
      MDC = 1'b0;
      st_oe = 1'b0;
      repeat (h + 4) @(negedge CLK);
   endtask

   task automatic frame(input bit rd, input logic [4:0] phy, input logic [4:0] ra,
                        input logic [15:0] d, input int pre, input int rst_at,
                        output logic [15:0] q);
      bit s;
      q = '0;
      repeat (pre) cyc(1'b1, 1'b1, s);
      send({50'd0, rd ? 4'b0110 : 4'b0101, phy, ra}, 14);
      if (rd) begin
         cyc(1'b0, 1'b0, s);
         chk("ta1_release", {31'd0, MDIO_T}, 32'd1);
         cyc(1'b0, 1'b0, s);
         chk("ta2_drive", {30'd0, MDIO_T, s}, 32'd0);
         for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, s);
            q[15-i] = s;
            if (i == rst_at) begin
               @(negedge CLK);
               RESET = 1'b1;
               @(negedge CLK);
               RESET = 1'b0;
               chk("rst_release", {31'd0, MDIO_T}, 32'd1);
               chk("rst_busy", {31'd0, BUSY}, 32'd0);
               return;
            end
         end
      end else begin
         cyc(1'b1, 1'b1, s);
         cyc(1'b1, 1'b0, s);
         for (int i = 15; i >= 0; i--) cyc(1'b1, d[i], s);
      end
      idle_low();
   endtask

   task automatic wr(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d, input int pre);
      logic [15:0] q;
      if (phy == 5'd1 && pre >= 32) sb.push_back('{1'b1, ra, d});
      frame(1'b0, phy, ra, d, pre, -1, q);
   endtask

   task automatic rd(input logic [4:0] ra, input int rst_at, output logic [15:0] q);
      sb.push_back('{1'b0, ra, 16'h0});
      frame(1'b1, 5'd1, ra, 16'h0, 32, rst_at, q);
   endtask

   initial begin
      logic [15:0] q;
      logic [15:0] wd [5];
      bit s;
      repeat (4) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_mdio_t", {31'd0, MDIO_T}, 32'd1);
      chk("rst_mdio_o", {31'd0, MDIO_O}, 32'd1);
      chk("rst_strobes", {30'd0, REG_WR, REG_RD}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_addr", {27'd0, REG_ADDR}, 32'd0);
      chk("rst_wdata", {16'd0, REG_WDATA}, 32'd0);

      t_low_seen = 1'b0;
      wr(5'd1, 5'd3, 16'hA5C3, 32);
      chk("t1_sb_empty", sb.size(), 0);
      chk("t1_line_released", {31'd0, t_low_seen}, 32'd0);
      chk("t1_addr_held", {27'd0, REG_ADDR}, 32'd3);

      rd(5'd3, -1, q);
      chk("t2_rdata", {16'd0, q}, 32'hA5C3);
      chk("t2_release", {31'd0, MDIO_T}, 32'd1);
      chk("t2_sb_empty", sb.size(), 0);

      t_low_seen = 1'b0;
      wr(5'd2, 5'd4, 16'hFFFF, 32);
      chk("t3_skip_released", {31'd0, t_low_seen}, 32'd0);
      chk("t3_skip_busy", {31'd0, BUSY}, 32'd0);
      wr(5'd1, 5'd4, 16'hFFFF, 32);
      chk("t3_sb_empty", sb.size(), 0);
      chk("t3_wdata", {16'd0, REG_WDATA}, 32'hFFFF);

      wr(5'd1, 5'd6, 16'h0000, 31);
      chk("t4_short_pre_busy", {31'd0, BUSY}, 32'd0);
      send({32'd0, 32'hFFFFFFFF}, 32);
      send(64'b0111, 4);
      chk("t4_op11_busy", {31'd0, BUSY}, 32'd0);
      send(64'b1010, 4);
      idle_low();
      chk("t4_abort_sb_empty", sb.size(), 0);
      wr(5'd1, 5'd6, 16'h0F0F, 32);
      chk("t4_recover_sb_empty", sb.size(), 0);

      wr(5'd1, 5'd0, 16'h5A0F, 32);
      rd(5'd3, 8, q);
      idle_low();
      chk("t5_sb_empty", sb.size(), 0);
      rd(5'd0, -1, q);
      chk("t5_rdata", {16'd0, q}, 32'h5A0F);

      for (int div = 0; div < 3; div++) begin
         h = 4 + div;
         for (int r = 0; r < 5; r++) begin
            wd[r] = 16'($urandom);
            wr(5'd1, 5'(r), wd[r], 32);
         end
         for (int r = 0; r < 5; r++) begin
            rd(5'(r), -1, q);
            chk($sformatf("t6_loop_div%0d_r%0d", div, r), {16'd0, q}, {16'd0, wd[r]});
         end
      end
      chk("t6_sb_empty", sb.size(), 0);
      chk("end_release", {31'd0, MDIO_T}, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
